// File: rtl/map_line_fetcher.sv
// map_line_fetcher: per-scanline tile number fetch from map/status RAM
// into a double-buffered line buffer read by the pixel renderer.
//
// Ports:
//   clock, reset (async, active-low)
//   line_start, line_y           : start fetch for next line, swap buffers
//   map_a_read/row/col/data      : map RAM port a (data 1 clk after read)
//   status_a_read/col/data       : status RAM port a (data 1 clk after read)
//   disp_col -> disp_tile        : registered front-buffer read, 1 clk
//   busy, overrun, overrun_clear : fetch activity and sticky overrun flag
module map_line_fetcher #(
    parameter int TILE_SHIFT  = 4,
    parameter int STATUS_ROWS = 1,
    parameter int Y_WIDTH     = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               line_start,
    input  logic [Y_WIDTH-1:0] line_y,
    output logic               map_a_read,
    output logic [4:0]         map_a_row,
    output logic [4:0]         map_a_col,
    input  logic [7:0]         map_a_data,
    output logic               status_a_read,
    output logic [4:0]         status_a_col,
    input  logic [7:0]         status_a_data,
    input  logic [4:0]         disp_col,
    output logic [7:0]         disp_tile,
    output logic               busy,
    output logic               overrun,
    input  logic               overrun_clear
);

    localparam logic [Y_WIDTH-1:0] LP_SROWS = Y_WIDTH'(STATUS_ROWS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN
    } state_t;

    state_t       r_state;
    state_t       w_next;
    logic [4:0]   r_col;
    logic [4:0]   r_row;
    logic         r_src;
    logic         r_sel;
    logic         r_cap_vld;
    logic [4:0]   r_cap_col;
    logic         r_overrun;
    logic [7:0]   r_disp;
    logic [7:0]   r_buf0 [0:31];
    logic [7:0]   r_buf1 [0:31];

    logic         w_is_status;
    logic [4:0]   w_row;
    logic         w_cap_we;
    logic [7:0]   w_cap_data;

    assign w_is_status = (line_y >> TILE_SHIFT) < LP_SROWS;
    assign w_row       = line_y[TILE_SHIFT+4:TILE_SHIFT];
    // A line_start drops any in-flight capture so the new back
    // buffer never receives data from the aborted fetch.
    assign w_cap_we    = r_cap_vld && !line_start;
    assign w_cap_data  = r_src ? status_a_data : map_a_data;

    always_comb begin
        w_next = r_state;
        if (line_start) begin
            w_next = S_FETCH;
        end else begin
            unique case (r_state)
                S_FETCH: if (r_col == 5'd31) w_next = S_DRAIN;
                S_DRAIN: w_next = S_IDLE;
                default: w_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_col     <= '0;
            r_row     <= '0;
            r_src     <= 1'b0;
            r_sel     <= 1'b0;
            r_cap_vld <= 1'b0;
            r_cap_col <= '0;
            r_overrun <= 1'b0;
            r_disp    <= '0;
        end else begin
            // Uses the select before any swap this clock.
            r_disp    <= r_sel ? r_buf1[disp_col] : r_buf0[disp_col];
            r_cap_vld <= (r_state == S_FETCH) && !line_start;
            r_cap_col <= r_col;
            if (line_start && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end else if (overrun_clear) begin
                r_overrun <= 1'b0;
            end
            if (line_start) begin
                r_sel <= ~r_sel;
                r_row <= w_row;
                r_src <= w_is_status;
                r_col <= '0;
            end else if ((r_state == S_FETCH) && (r_col != 5'd31)) begin
                r_col <= r_col + 5'd1;
            end
        end
    end

    // Line buffers hold no reset; back buffer is the one not selected.
    always_ff @(posedge clock) begin
        if (w_cap_we) begin
            if (r_sel) begin
                r_buf0[r_cap_col] <= w_cap_data;
            end else begin
                r_buf1[r_cap_col] <= w_cap_data;
            end
        end
    end

    assign map_a_read    = (r_state == S_FETCH) && !r_src;
    assign status_a_read = (r_state == S_FETCH) && r_src;
    assign map_a_row     = r_row;
    assign map_a_col     = r_col;
    assign status_a_col  = r_col;
    assign busy          = (r_state != S_IDLE);
    assign overrun       = r_overrun;
    assign disp_tile     = r_disp;

endmodule

// File: tb/tb_map_line_fetcher.sv
// tb_map_line_fetcher: randomized bench for map_line_fetcher with a
// line-level reference model of fetch timing and buffer contents.
module tb_map_line_fetcher;

    logic       clock = 1'b0;
    logic       reset;
    logic       line_start;
    logic [9:0] line_y;
    logic       map_a_read;
    logic [4:0] map_a_row;
    logic [4:0] map_a_col;
    logic [7:0] map_a_data;
    logic       status_a_read;
    logic [4:0] status_a_col;
    logic [7:0] status_a_data;
    logic [4:0] disp_col;
    logic [7:0] disp_tile;
    logic       busy;
    logic       overrun;
    logic       overrun_clear;

    map_line_fetcher dut (
        .clock         (clock),
        .reset         (reset),
        .line_start    (line_start),
        .line_y        (line_y),
        .map_a_read    (map_a_read),
        .map_a_row     (map_a_row),
        .map_a_col     (map_a_col),
        .map_a_data    (map_a_data),
        .status_a_read (status_a_read),
        .status_a_col  (status_a_col),
        .status_a_data (status_a_data),
        .disp_col      (disp_col),
        .disp_tile     (disp_tile),
        .busy          (busy),
        .overrun       (overrun),
        .overrun_clear (overrun_clear)
    );

    always #5 clock = ~clock;

    logic [7:0] map_mem [0:31][0:31];
    logic [7:0] status_mem [0:31];

    always @(posedge clock) begin
        if (map_a_read) map_a_data <= map_mem[map_a_row][map_a_col];
        if (status_a_read) status_a_data <= status_mem[status_a_col];
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase = clocks since line_start (0 = idle),
    // pend = line being fetched, front = line the renderer sees.
    int         ph;
    logic       m_src;
    logic [4:0] m_row;
    logic [7:0] front [0:31];
    logic [7:0] pend [0:31];
    bit         front_ok;
    bit         pend_ok;
    bit         ovr;

    task automatic set_pend(input logic [9:0] y);
        int r;
        r = int'(y) >> 4;
        m_src = (r < 1);
        m_row = 5'(r % 32);
        for (int c = 0; c < 32; c++)
            pend[c] = m_src ? status_mem[c] : map_mem[m_row][c];
    endtask

    task automatic tick(input bit ls, input logic [9:0] y,
                        input bit clr, input int dcs);
        logic [4:0] dc;
        logic [7:0] exp_d;
        bit         exp_ok;
        dc = (dcs < 0) ? 5'($urandom_range(0, 31)) : 5'(dcs);
        line_start    = ls;
        line_y        = y;
        overrun_clear = clr;
        disp_col      = dc;
        exp_d  = front[dc];
        exp_ok = front_ok;
        if (ls && ph != 0) ovr = 1;
        else if (clr) ovr = 0;
        if (ls) begin
            front    = pend;
            front_ok = pend_ok;
            pend_ok  = 0;
            set_pend(y);
            ph = 1;
        end else if (ph != 0) begin
            ph++;
            if (ph == 34) begin
                ph = 0;
                pend_ok = 1;
            end
        end
        @(posedge clock);
        #1;
        line_start    = 1'b0;
        overrun_clear = 1'b0;
        chk("busy", 32'(busy), 32'(ph != 0));
        chk("overrun", 32'(overrun), 32'(ovr));
        if (ph >= 1 && ph <= 32) begin
            chk("map_rd", 32'(map_a_read), 32'(!m_src));
            chk("st_rd", 32'(status_a_read), 32'(m_src));
            if (m_src) begin
                chk("st_col", 32'(status_a_col), 32'(ph - 1));
            end else begin
                chk("map_col", 32'(map_a_col), 32'(ph - 1));
                chk("map_row", 32'(map_a_row), 32'(m_row));
            end
        end else begin
            chk("map_rd_off", 32'(map_a_read), 32'd0);
            chk("st_rd_off", 32'(status_a_read), 32'd0);
        end
        if (exp_ok) chk("disp", 32'(disp_tile), 32'(exp_d));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 10'd0, 0, -1);
    endtask

    task automatic line(input logic [9:0] y);
        tick(1, y, 0, -1);
        idle(33);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ovr"}, 32'(overrun), 32'd0);
        chk({tag, "_mrd"}, 32'(map_a_read), 32'd0);
        chk({tag, "_srd"}, 32'(status_a_read), 32'd0);
        chk({tag, "_disp"}, 32'(disp_tile), 32'd0);
        chk({tag, "_mcol"}, 32'(map_a_col), 32'd0);
        chk({tag, "_scol"}, 32'(status_a_col), 32'd0);
        chk({tag, "_row"}, 32'(map_a_row), 32'd0);
    endtask

    initial begin
        reset         = 1'b0;
        line_start    = 1'b0;
        line_y        = '0;
        overrun_clear = 1'b0;
        disp_col      = '0;
        ph = 0; ovr = 0; front_ok = 0; pend_ok = 0;
        m_src = 0; m_row = '0;
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                map_mem[r][c] = 8'($urandom);
        for (int c = 0; c < 32; c++) begin
            map_mem[5][c] = 8'(c);
            status_mem[c] = 8'(8'hA0 + c);
        end
        for (int c = 0; c < 32; c++) begin
            front[c] = '0;
            pend[c]  = '0;
        end

        repeat (2) @(posedge clock);
        #1;
        chk_reset("rst");
        reset = 1'b1;
        idle(3);

        // Row 5 fetch, then explicit sweep of the swapped-in front buffer.
        line(10'd80);
        tick(1, 10'd96, 0, -1);
        for (int c = 0; c < 32; c++) tick(0, 10'd0, 0, c);
        idle(1);

        // Status row source, then a high line number that wraps the row.
        line(10'd3);
        line(10'd1000);
        line(10'd500);

        repeat (6) line(10'($urandom));

        // Overrun at clock 10 of a fetch, clear, then set-wins-over-clear.
        tick(1, 10'd200, 0, -1);
        idle(9);
        tick(1, 10'd300, 0, -1);
        idle(33);
        tick(0, 10'd0, 1, -1);
        tick(1, 10'd400, 0, -1);
        idle(5);
        tick(1, 10'd420, 1, -1);
        idle(33);
        tick(0, 10'd0, 1, -1);
        // Held line_start counts twice.
        tick(1, 10'd50, 0, -1);
        tick(1, 10'd60, 0, -1);
        idle(33);
        tick(0, 10'd0, 1, -1);
        line(10'd700);
        line(10'd720);

        // Random line_start / overrun_clear traffic.
        for (int i = 0; i < 150; i++)
            tick($urandom_range(0, 24) == 0, 10'($urandom),
                 $urandom_range(0, 9) == 0, -1);
        idle(34);

        // Asynchronous reset in the middle of a fetch.
        tick(1, 10'd640, 0, -1);
        idle(5);
        #3;
        reset = 1'b0;
        #1;
        chk_reset("arst");
        ph = 0; ovr = 0; front_ok = 0; pend_ok = 0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        idle(5);
        line(10'd160);
        line(10'd176);
        line(10'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
